// File: rtl/npu_host_seq.sv
// Host-side sequencer that drives a full NPU inference (load, conv1/conv2, fc1 stream, readback) over the BRAM-style port.
// Define NPU_HOST_SEQ_PERF_EN to add the o_cyc_cnt busy-cycle counter.
module npu_host_seq #(
    parameter int          IMG_WORDS  = 60,
    parameter int          WC_WORDS   = 3,
    parameter int          FC2_WORDS  = 3,
    parameter int          FC1_GROUPS = 330,
    parameter int          SRC_AW     = 10,
    parameter int          CONV_WAIT  = 256,
    parameter int          FC_GAP     = 8,
    parameter logic [15:0] RD_ADDR    = 16'h6000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic [23:0]       o_result,
    output logic [SRC_AW-1:0] o_src_addr,
    input  logic [31:0]       i_src_rdata,
    output logic              o_ena,
    output logic              o_wea,
    output logic [15:0]       o_addra,
    output logic [31:0]       o_dina,
    input  logic [31:0]       i_douta
`ifdef NPU_HOST_SEQ_PERF_EN
    ,
    output logic [31:0]       o_cyc_cnt
`endif
);

    localparam int FC1_BASE = IMG_WORDS + WC_WORDS + FC2_WORDS;
    localparam int WAIT_MAX = (CONV_WAIT > FC_GAP) ? CONV_WAIT : FC_GAP;
    localparam int WW       = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam int GW       = (FC1_GROUPS > 1) ? $clog2(FC1_GROUPS) : 1;
    localparam logic [2:0] SEL_CTRL = 3'b101;

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_LD_IMG  = 4'd1;
    localparam logic [3:0] S_LD_WC   = 4'd2;
    localparam logic [3:0] S_LD_FC2  = 4'd3;
    localparam logic [3:0] S_TRIG1   = 4'd4;
    localparam logic [3:0] S_WAIT1   = 4'd5;
    localparam logic [3:0] S_NEXT1   = 4'd6;
    localparam logic [3:0] S_TRIG2   = 4'd7;
    localparam logic [3:0] S_WAIT2   = 4'd8;
    localparam logic [3:0] S_NEXT2   = 4'd9;
    localparam logic [3:0] S_FC_LOOP = 4'd10;
    localparam logic [3:0] S_RD      = 4'd11;
    localparam logic [3:0] S_CAP     = 4'd12;
    localparam logic [3:0] S_FIN     = 4'd13;

    logic [3:0]  r_state;
    logic [11:0] r_idx;
    logic [2:0]  r_sub;
    logic [WW-1:0] r_wait;
    logic [GW-1:0] r_grp;
    logic [23:0] r_result;

    logic              w_ld_last;
    logic [3:0]        w_ld_next;
    logic [2:0]        w_ld_sel;
    logic [SRC_AW-1:0] w_ld_base;
    logic              w_unused;

    assign w_unused = ^i_douta[31:24];

    always_comb begin
        w_ld_last = 1'b0;
        w_ld_next = S_IDLE;
        w_ld_sel  = 3'b000;
        w_ld_base = '0;
        case (r_state)
            S_LD_IMG: begin
                w_ld_last = (r_idx == 12'(IMG_WORDS - 1));
                w_ld_next = S_LD_WC;
                w_ld_sel  = 3'b001;
            end
            S_LD_WC: begin
                w_ld_last = (r_idx == 12'(WC_WORDS - 1));
                w_ld_next = S_LD_FC2;
                w_ld_sel  = 3'b010;
                w_ld_base = SRC_AW'(IMG_WORDS);
            end
            S_LD_FC2: begin
                w_ld_last = (r_idx == 12'(FC2_WORDS - 1));
                w_ld_next = S_TRIG1;
                w_ld_sel  = 3'b100;
                w_ld_base = SRC_AW'(IMG_WORDS + WC_WORDS);
            end
            default: ;
        endcase
    end

    // r_sub sequences the sub-steps of a region word (0=fetch, 1=write) and of an fc1 group (0..4).
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_sub    <= '0;
            r_wait   <= '0;
            r_grp    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state  <= S_LD_IMG;
                        r_result <= '0;
                        r_idx    <= '0;
                        r_sub    <= '0;
                    end
                end
                S_LD_IMG, S_LD_WC, S_LD_FC2: begin
                    if (r_sub == 3'd0) begin
                        r_sub <= 3'd1;
                    end else begin
                        r_sub <= 3'd0;
                        if (w_ld_last) begin
                            r_idx   <= '0;
                            r_state <= w_ld_next;
                        end else begin
                            r_idx <= r_idx + 12'd1;
                        end
                    end
                end
                S_TRIG1: begin
                    r_wait  <= '0;
                    r_state <= S_WAIT1;
                end
                S_WAIT1: begin
                    if (r_wait == WW'(CONV_WAIT - 1)) r_state <= S_NEXT1;
                    else                              r_wait  <= r_wait + 1'b1;
                end
                S_NEXT1: r_state <= S_TRIG2;
                S_TRIG2: begin
                    r_wait  <= '0;
                    r_state <= S_WAIT2;
                end
                S_WAIT2: begin
                    if (r_wait == WW'(CONV_WAIT - 1)) r_state <= S_NEXT2;
                    else                              r_wait  <= r_wait + 1'b1;
                end
                S_NEXT2: begin
                    r_grp   <= '0;
                    r_sub   <= '0;
                    r_wait  <= '0;
                    r_state <= S_FC_LOOP;
                end
                S_FC_LOOP: begin
                    case (r_sub)
                        3'd0, 3'd1, 3'd2: r_sub <= r_sub + 3'd1;
                        3'd3: begin
                            r_wait <= '0;
                            r_sub  <= 3'd4;
                        end
                        3'd4: begin
                            if (r_wait == WW'(FC_GAP - 1)) begin
                                r_wait <= '0;
                                r_sub  <= 3'd0;
                                if (r_grp == GW'(FC1_GROUPS - 1)) r_state <= S_RD;
                                else                              r_grp   <= r_grp + 1'b1;
                            end else begin
                                r_wait <= r_wait + 1'b1;
                            end
                        end
                        default: r_sub <= 3'd0;
                    endcase
                end
                S_RD:  r_state <= S_CAP;
                S_CAP: begin
                    r_result <= i_douta[23:0];
                    r_state  <= S_FIN;
                end
                S_FIN:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        o_ena      = 1'b0;
        o_wea      = 1'b0;
        o_addra    = 16'h0000;
        o_dina     = 32'h0;
        o_src_addr = '0;
        case (r_state)
            S_LD_IMG, S_LD_WC, S_LD_FC2: begin
                o_src_addr = w_ld_base + SRC_AW'(r_idx);
                if (r_sub[0]) begin
                    o_ena   = 1'b1;
                    o_wea   = 1'b1;
                    o_addra = {1'b0, w_ld_sel, r_idx};
                    o_dina  = i_src_rdata;
                end
            end
            S_TRIG1, S_TRIG2, S_NEXT1, S_NEXT2: begin
                o_ena   = 1'b1;
                o_wea   = 1'b1;
                o_addra = {1'b0, SEL_CTRL, 12'd0};
                o_dina  = ((r_state == S_NEXT1) || (r_state == S_NEXT2)) ? 32'h8 : 32'h1;
            end
            S_FC_LOOP: begin
                o_src_addr = SRC_AW'(FC1_BASE) + SRC_AW'(r_grp);
                case (r_sub)
                    3'd1: begin
                        o_ena   = 1'b1;
                        o_wea   = 1'b1;
                        o_addra = {1'b0, 3'b011, 12'd0};
                        o_dina  = i_src_rdata;
                    end
                    3'd2, 3'd3: begin
                        o_ena   = 1'b1;
                        o_wea   = 1'b1;
                        o_addra = {1'b0, SEL_CTRL, 9'd0, r_sub};
                    end
                    default: ;
                endcase
            end
            S_RD: begin
                o_ena   = 1'b1;
                o_addra = RD_ADDR;
            end
            default: ;
        endcase
    end

    assign o_busy   = (r_state != S_IDLE) && (r_state != S_FIN);
    assign o_done   = (r_state == S_FIN);
    assign o_result = r_result;

`ifdef NPU_HOST_SEQ_PERF_EN
    logic [31:0] r_cyc_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)                             r_cyc_cnt <= '0;
        else if (r_state == S_IDLE && i_start) r_cyc_cnt <= '0;
        else if (o_busy)                       r_cyc_cnt <= r_cyc_cnt + 32'd1;
    end

    assign o_cyc_cnt = r_cyc_cnt;
`endif

endmodule
